// File: rtl/chacha_block_core.sv
`default_nettype none
// ============================================================================
// chacha_block_core : multi-cycle ChaCha block function, LANES quarter-rounds
// per group, two cycles (AD then BC) per quarter-round.  Rev 1.0
// ============================================================================
module chacha_block_core #(
  parameter int LANES    = 4,
  parameter int ROUNDS   = 20,
  parameter int FEED_FWD = 1
) (
  input  logic         g_clk,
  input  logic         g_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
);

  localparam int GROUPS = 4 / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int DR     = ROUNDS / 2;
  localparam int DW     = (DR > 1) ? $clog2(DR) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AD   = 3'd1,
    BC   = 3'd2,
    FF   = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     work [16];
  logic [GW-1:0]   grp;
  logic            diag;
  logic [DW-1:0]   dround;
  logic            last_grp, last_dr, accept;
  logic [511:0]    result;

  logic [3:0]      la [LANES];
  logic [3:0]      lb [LANES];
  logic [3:0]      lc [LANES];
  logic [3:0]      ld [LANES];
  logic [31:0]     ad_a [LANES];
  logic [31:0]     ad_d [LANES];
  logic [31:0]     bc_b [LANES];
  logic [31:0]     bc_c [LANES];

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  assign last_grp = (grp == GW'(GROUPS - 1));
  assign last_dr  = (dround == DW'(DR - 1));
  assign accept   = (state == IDLE) && in_valid;
  assign in_ready = (state == IDLE);
  assign busy     = (state == AD) || (state == BC) || (state == FF);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [1:0]  q;
    logic [31:0] a, b, c, d, xa, xb, xc, xd, yb, yc, yd;

    // Diagonal half-round rotates the b/c/d rows by 1/2/3 words.
    assign q     = 2'(int'(grp) * LANES + k);
    assign la[k] = {2'b00, q};
    assign lb[k] = {2'b01, (diag ? q + 2'd1 : q)};
    assign lc[k] = {2'b10, (diag ? q + 2'd2 : q)};
    assign ld[k] = {2'b11, (diag ? q + 2'd3 : q)};

    assign a = work[la[k]];
    assign b = work[lb[k]];
    assign c = work[lc[k]];
    assign d = work[ld[k]];

    assign xa      = a + b;
    assign xd      = rol(xa ^ d, 16);
    assign xc      = c + xd;
    assign xb      = rol(b ^ xc, 12);
    assign ad_a[k] = xa + xb;
    assign ad_d[k] = rol(ad_a[k] ^ xd, 8);

    // BC recovers the intermediate d from the updated a/d pair.
    assign yd      = rol(d, 24) ^ a;
    assign yc      = c + yd;
    assign yb      = rol(b ^ yc, 12);
    assign bc_c[k] = yc + d;
    assign bc_b[k] = rol(bc_c[k] ^ yb, 7);
  end

  if (FEED_FWD != 0) begin : g_fwd
    logic [31:0] copy [16];
    always_ff @(posedge g_clk or posedge g_rst) begin
      if (g_rst) begin
        for (int i = 0; i < 16; i++) copy[i] <= '0;
      end else if (accept) begin
        for (int i = 0; i < 16; i++) copy[i] <= in_state[32*i +: 32];
      end
    end
    for (genvar i = 0; i < 16; i++) begin : g_sum
      assign result[32*i +: 32] = work[i] + copy[i];
    end
  end else begin : g_raw
    for (genvar i = 0; i < 16; i++) begin : g_word
      assign result[32*i +: 32] = work[i];
    end
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = AD;
      AD:      state_nx = BC;
      BC:      state_nx = (last_grp && diag && last_dr) ? FF : AD;
      FF:      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_rst) begin
    if (g_rst) begin
      for (int i = 0; i < 16; i++) work[i] <= '0;
      grp       <= '0;
      diag      <= 1'b0;
      dround    <= '0;
      out_state <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < 16; i++) work[i] <= in_state[32*i +: 32];
            grp    <= '0;
            diag   <= 1'b0;
            dround <= '0;
          end
        end
        AD: begin
          for (int k = 0; k < LANES; k++) begin
            work[la[k]] <= ad_a[k];
            work[ld[k]] <= ad_d[k];
          end
        end
        BC: begin
          for (int k = 0; k < LANES; k++) begin
            work[lb[k]] <= bc_b[k];
            work[lc[k]] <= bc_c[k];
          end
          if (last_grp) begin
            grp  <= '0;
            diag <= ~diag;
            if (diag && !last_dr) dround <= dround + 1'b1;
          end else begin
            grp <= grp + 1'b1;
          end
        end
        FF: begin
          out_state <= result;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chacha_block_core.sv
`default_nettype none
// ============================================================================
// tb_chacha_block_core : RFC 8439 vectors and random blocks over six configs.
// ============================================================================
module tb_chacha_block_core;

  localparam int ND = 6;

  function automatic int cfg_lanes(input int j);
    case (j)
      2:       return 1;
      3:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int cfg_rounds(input int j);
    case (j)
      4:       return 8;
      5:       return 12;
      default: return 20;
    endcase
  endfunction

  function automatic int cfg_ff(input int j);
    return (j == 1) ? 0 : 1;
  endfunction

  logic         g_clk = 1'b0;
  logic         g_rst;
  logic         iv   [ND];
  logic         ir   [ND];
  logic         ov   [ND];
  logic         ordy [ND];
  logic         bz   [ND];
  logic [511:0] ist  [ND];
  logic [511:0] ost  [ND];

  int tests = 0;
  int fails = 0;

  for (genvar j = 0; j < ND; j++) begin : g_dut
    chacha_block_core #(
      .LANES   (cfg_lanes(j)),
      .ROUNDS  (cfg_rounds(j)),
      .FEED_FWD(cfg_ff(j))
    ) u_dut (
      .g_clk    (g_clk),
      .g_rst    (g_rst),
      .in_valid (iv[j]),
      .in_ready (ir[j]),
      .in_state (ist[j]),
      .out_valid(ov[j]),
      .out_ready(ordy[j]),
      .out_state(ost[j]),
      .busy     (bz[j])
    );
  end

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  // Textbook ChaCha block function: column then diagonal quarter-rounds.
  function automatic logic [511:0] ref_block(input logic [511:0] st, input int rounds, input int ff);
    logic [31:0]  x [16];
    logic [511:0] r;
    int qt [8][4];
    int a, b, c, d;
    qt = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
           '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
    for (int r2 = 0; r2 < rounds / 2; r2++) begin
      for (int q = 0; q < 8; q++) begin
        a = qt[q][0]; b = qt[q][1]; c = qt[q][2]; d = qt[q][3];
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[c] = x[c] + x[d]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    end
    for (int i = 0; i < 16; i++)
      r[32*i +: 32] = (ff != 0) ? x[i] + st[32*i +: 32] : x[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_block(input int j, input logic [511:0] st,
                           output logic [511:0] res, output int lat, output int bcnt);
    int guard = 0;
    while (!ir[j] && guard < 2000) begin
      @(posedge g_clk); #1; guard++;
    end
    ist[j] = st;
    iv[j]  = 1'b1;
    @(posedge g_clk); #1;
    iv[j] = 1'b0;
    lat  = 0;
    bcnt = bz[j] ? 1 : 0;
    while (!ov[j] && lat < 2000) begin
      @(posedge g_clk); #1;
      lat++;
      if (bz[j]) bcnt++;
    end
    res = ost[j];
  endtask

  task automatic release_out(input int j);
    ordy[j] = 1'b1;
    @(posedge g_clk); #1;
    ordy[j] = 1'b0;
  endtask

  function automatic logic [511:0] rand_state();
    logic [511:0] s;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  typedef struct {
    int          j;
    logic [31:0] w0, w1, w15;
    bit          chk;
    int          lat;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt [6];
    logic [31:0]  rfcw [16];
    logic [511:0] rfc, res, exp, st, held;
    int           lat, bcnt;
    bit           stable;

    rfcw = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
             32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
             32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
             32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
    for (int i = 0; i < 16; i++) rfc[32*i +: 32] = rfcw[i];

    vt[0] = '{0, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2, 1'b1, 41};
    vt[1] = '{1, 32'h837778ab, 32'he238d763, 32'h4e3c50a2, 1'b1, 41};
    vt[2] = '{2, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2, 1'b1, 161};
    vt[3] = '{3, 32'he4e7f110, 32'h15593bd1, 32'h4e3c50a2, 1'b1, 81};
    vt[4] = '{4, 32'h0, 32'h0, 32'h0, 1'b0, 17};
    vt[5] = '{5, 32'h0, 32'h0, 32'h0, 1'b0, 25};

    for (int j = 0; j < ND; j++) begin
      iv[j] = 1'b0; ordy[j] = 1'b0; ist[j] = '0;
    end
    g_rst = 1'b1;
    repeat (3) @(posedge g_clk);
    #1;
    for (int j = 0; j < ND; j++) begin
      check($sformatf("reset_flags[%0d]", j), 512'({ir[j], ov[j], bz[j]}), 512'(3'b100));
      check($sformatf("reset_out[%0d]", j), ost[j], '0);
    end
    #2 g_rst = 1'b0;

    // RFC vector across all configurations.
    for (int v = 0; v < 6; v++) begin
      int j;
      j = vt[v].j;
      run_block(j, rfc, res, lat, bcnt);
      check($sformatf("rfc_latency[%0d]", j), 512'(lat), 512'(vt[v].lat));
      check($sformatf("rfc_busy[%0d]", j), 512'(bcnt), 512'(vt[v].lat));
      exp = ref_block(rfc, cfg_rounds(j), cfg_ff(j));
      check($sformatf("rfc_model[%0d]", j), res, exp);
      if (vt[v].chk)
        check($sformatf("rfc_words[%0d]", j), 512'({res[511:480], res[63:32], res[31:0]}),
              512'({vt[v].w15, vt[v].w1, vt[v].w0}));
      release_out(j);
      check($sformatf("rfc_return_idle[%0d]", j), 512'({ir[j], ov[j]}), 512'(2'b10));
    end

    // Backpressure: result held, new offers ignored, then a second block.
    run_block(0, rfc, held, lat, bcnt);
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      iv[0]  = 1'b1;
      ist[0] = rand_state();
      @(posedge g_clk); #1;
      if (ost[0] !== held || ir[0] !== 1'b0 || ov[0] !== 1'b1) stable = 1'b0;
    end
    iv[0] = 1'b0;
    check("bp_hold", 512'(stable), 512'(1));
    release_out(0);
    check("bp_release", 512'({ir[0], ov[0], bz[0]}), 512'(3'b100));
    st = rand_state();
    run_block(0, st, res, lat, bcnt);
    check("bp_second_latency", 512'(lat), 512'(41));
    check("bp_second_data", res, ref_block(st, 20, 1));
    release_out(0);

    // Asynchronous abort mid-block, then a clean re-run.
    ist[0] = rfc;
    iv[0]  = 1'b1;
    @(posedge g_clk); #1;
    iv[0] = 1'b0;
    repeat (14) @(posedge g_clk);
    #2 g_rst = 1'b1;
    #1;
    check("abort_flags", 512'({ir[0], ov[0], bz[0]}), 512'(3'b100));
    check("abort_out", ost[0], '0);
    #3 g_rst = 1'b0;
    run_block(0, rfc, res, lat, bcnt);
    check("abort_rerun_latency", 512'(lat), 512'(41));
    check("abort_rerun_data", res, ref_block(rfc, 20, 1));
    release_out(0);

    // Random blocks on every configuration.
    for (int j = 0; j < ND; j++) begin
      for (int n = 0; n < 3; n++) begin
        st = rand_state();
        run_block(j, st, res, lat, bcnt);
        check($sformatf("rand_data[%0d.%0d]", j, n), res,
              ref_block(st, cfg_rounds(j), cfg_ff(j)));
        repeat ($urandom_range(0, 3)) @(posedge g_clk);
        #1;
        release_out(j);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
